// File: rtl/shared_mem_pkg.sv
// Shared definitions for the shared-memory bank front-ends.
package shared_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned N_BANKS    = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit strictly after ptr, wrapping mod N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // i == N wraps back to ptr itself, so the last winner is considered last.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// Round-robin request front-end for one shared-memory bank; fully registered outputs.
module bank_arbiter
  import shared_mem_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     bank_read,
  output logic                     bank_write,
  output logic [ADDR_W-1:0]        bank_addr,
  output logic [DATA_W-1:0]        bank_wdata,
  input  logic [DATA_W-1:0]        bank_rdata,
  input  logic                     bank_finish
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              bank_read_q, bank_read_d;
  logic              bank_write_q, bank_write_d;
  logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
  logic [DATA_W-1:0] bank_wdata_q, bank_wdata_d;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    ack_d        = ack_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    bank_read_d  = bank_read_q;
    bank_write_d = bank_write_q;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_d        = pick_idx;
          wr_d         = req_write[pick_idx];
          bank_addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          bank_wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
          bank_read_d  = ~req_write[pick_idx];
          bank_write_d = req_write[pick_idx];
          state_d      = StIssue;
        end
      end
      StIssue: begin
        bank_read_d  = 1'b0;
        bank_write_d = 1'b0;
        cnt_d        = '0;
        state_d      = StWait;
      end
      StWait: begin
        if (bank_finish) begin
          rdata_d       = wr_q ? '0 : bank_rdata;
          err_d         = 1'b0;
          ack_d         = '0;
          ack_d[gnt_q]  = 1'b1;
          state_d       = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d       = '0;
          err_d         = 1'b1;
          ack_d         = '0;
          ack_d[gnt_q]  = 1'b1;
          state_d       = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        // req_valid is deliberately ignored here so a held request is not served twice.
        ack_d    = '0;
        rdata_d  = '0;
        err_d    = 1'b0;
        rr_ptr_d = gnt_q;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= IDX_W'(N_REQ - 1);
      gnt_q        <= '0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      bank_read_q  <= 1'b0;
      bank_write_q <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      bank_read_q  <= bank_read_d;
      bank_write_q <= bank_write_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign bank_read  = bank_read_q;
  assign bank_write = bank_write_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;

endmodule
